// File: rtl/fs_tracker.sv
// Tracks a divided sample clock (clk_fs) in the clk_256fs domain: edge detection,
// period/phase measurement and a lock FSM that checks each period against NOMINAL_PERIOD.
module fs_tracker #(
   parameter int SYNC_STAGES    = 2,
   parameter int NOMINAL_PERIOD = 256,
   parameter int LOCK_COUNT     = 4,
   parameter int TIMEOUT        = 511
) (
   input  logic       clk_256fs,
   input  logic       rst,
   input  logic       clk_fs,
   output logic       fs_strobe,
   output logic [8:0] period,
   output logic [7:0] phase,
   output logic       locked,
   output logic       period_err,
   output logic [1:0] fsm_state,
   output logic [3:0] good_cnt
);

   typedef enum logic [1:0] {
      ST_UNLOCKED = 2'd0,
      ST_ACQUIRE  = 2'd1,
      ST_LOCKED   = 2'd2
   } state_t;

   localparam logic [8:0] NOM_CNT  = 9'(NOMINAL_PERIOD);
   localparam logic [8:0] TMO_CNT  = 9'(TIMEOUT);
   localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);
   localparam logic [8:0] CNT_MAX  = 9'h1FF;

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   hist_q, hist_d;
   logic                   strobe_q, strobe_d;
   logic [8:0]             cnt_q, cnt_d;
   logic [8:0]             period_q, period_d;
   logic                   seen_q, seen_d;
   state_t                 state_q, state_d;
   logic [3:0]             good_q, good_d;
   logic                   locked_q, locked_d;
   logic                   err_q, err_d;
   logic                   rise;

   always_comb begin
      sync_d   = {sync_q[SYNC_STAGES-2:0], clk_fs};
      hist_d   = sync_q[SYNC_STAGES-1];
      rise     = sync_q[SYNC_STAGES-1] & ~hist_q;
      strobe_d = rise;

      // cnt is 1 on the strobe cycle and saturates rather than wrapping
      if (rise) begin
         cnt_d = 9'd1;
      end else if (cnt_q == CNT_MAX) begin
         cnt_d = cnt_q;
      end else begin
         cnt_d = cnt_q + 9'd1;
      end

      // The first edge after reset only opens a period; it does not complete one
      seen_d   = seen_q | rise;
      period_d = (rise && seen_q) ? cnt_q : period_q;

      state_d = state_q;
      good_d  = good_q;
      err_d   = 1'b0;
      case (state_q)
         ST_UNLOCKED: begin
            if (rise) begin
               state_d = ST_ACQUIRE;
               good_d  = 4'd0;
            end
         end
         ST_ACQUIRE: begin
            if (rise) begin
               if (cnt_q == NOM_CNT) begin
                  good_d = good_q + 4'd1;
                  if (good_q + 4'd1 == LOCK_CNT) begin
                     state_d = ST_LOCKED;
                  end
               end else begin
                  good_d = 4'd0;
               end
            end else if (cnt_q == TMO_CNT) begin
               state_d = ST_UNLOCKED;
               good_d  = 4'd0;
            end
         end
         ST_LOCKED: begin
            if (rise) begin
               if (cnt_q != NOM_CNT) begin
                  state_d = ST_ACQUIRE;
                  good_d  = 4'd0;
                  err_d   = 1'b1;
               end
            end else if (cnt_q == TMO_CNT) begin
               state_d = ST_UNLOCKED;
               good_d  = 4'd0;
               err_d   = 1'b1;
            end
         end
         default: begin
            state_d = ST_UNLOCKED;
            good_d  = 4'd0;
         end
      endcase
      locked_d = (state_d == ST_LOCKED);
   end

   always_ff @(posedge clk_256fs or posedge rst) begin
      if (rst) begin
         sync_q   <= '0;
         hist_q   <= 1'b0;
         strobe_q <= 1'b0;
         cnt_q    <= 9'd0;
         period_q <= 9'd0;
         seen_q   <= 1'b0;
         state_q  <= ST_UNLOCKED;
         good_q   <= 4'd0;
         locked_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         sync_q   <= sync_d;
         hist_q   <= hist_d;
         strobe_q <= strobe_d;
         cnt_q    <= cnt_d;
         period_q <= period_d;
         seen_q   <= seen_d;
         state_q  <= state_d;
         good_q   <= good_d;
         locked_q <= locked_d;
         err_q    <= err_d;
      end
   end

   assign fs_strobe  = strobe_q;
   assign period     = period_q;
   assign phase      = cnt_q[8] ? 8'hFF : cnt_q[7:0];
   assign locked     = locked_q;
   assign period_err = err_q;
   assign fsm_state  = state_q;
   assign good_cnt   = good_q;

endmodule

// File: tb/tb_fs_tracker.sv
// Bench for fs_tracker: directed clk_fs period sequences; a monitor pops the expected
// {strobe, period, locked, period_err, state, good} snapshot on every strobe or error pulse.
module tb_fs_tracker;

   localparam int W = 18;

   logic       clk;
   logic       rst;
   logic       clk_fs;
   logic       fs_strobe;
   logic [8:0] period;
   logic [7:0] phase;
   logic       locked;
   logic       period_err;
   logic [1:0] fsm_state;
   logic [3:0] good_cnt;

   logic [W-1:0] exp_q[$];
   int           tests;
   int           fails;

   fs_tracker #(
      .SYNC_STAGES(2), .NOMINAL_PERIOD(256), .LOCK_COUNT(4), .TIMEOUT(511)
   ) dut (
      .clk_256fs (clk),
      .rst       (rst),
      .clk_fs    (clk_fs),
      .fs_strobe (fs_strobe),
      .period    (period),
      .phase     (phase),
      .locked    (locked),
      .period_err(period_err),
      .fsm_state (fsm_state),
      .good_cnt  (good_cnt)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [W-1:0] mk(input logic stb, input int per, input logic lck,
                                       input logic err, input int st, input int good);
      mk = {stb, 9'(per), lck, err, 2'(st), 4'(good)};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // driver tasks
   task automatic drive_cycle(input int len);
      clk_fs = 1'b1;
      repeat (len / 2) @(negedge clk);
      clk_fs = 1'b0;
      repeat (len - len / 2) @(negedge clk);
   endtask

   task automatic wait_empty(input string name, input int budget);
      for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL %s: %0d expected events outstanding, required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (!rst && (fs_strobe || period_err)) begin
         logic [W-1:0] act;
         act = {fs_strobe, period, locked, period_err, fsm_state, good_cnt};
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_event: got %0h with no expectation at %0t", act, $time);
         end else begin
            chk("event_snapshot", 32'(act), 32'(exp_q.pop_front()));
         end
      end
   end

   int           lens[17];
   logic [W-1:0] exp_tab[18];

   initial begin
      tests  = 0;
      fails  = 0;
      rst    = 1'b1;
      clk_fs = 1'b0;

      lens = '{256, 256, 256, 256, 300, 256, 256, 256, 256, 300, 255, 256, 255, 256, 256, 256, 256};
      exp_tab[0]  = mk(1, 0,   0, 0, 1, 0);
      exp_tab[1]  = mk(1, 256, 0, 0, 1, 1);
      exp_tab[2]  = mk(1, 256, 0, 0, 1, 2);
      exp_tab[3]  = mk(1, 256, 0, 0, 1, 3);
      exp_tab[4]  = mk(1, 256, 1, 0, 2, 4);
      exp_tab[5]  = mk(1, 300, 0, 1, 1, 0);
      exp_tab[6]  = mk(1, 256, 0, 0, 1, 1);
      exp_tab[7]  = mk(1, 256, 0, 0, 1, 2);
      exp_tab[8]  = mk(1, 256, 0, 0, 1, 3);
      exp_tab[9]  = mk(1, 256, 1, 0, 2, 4);
      exp_tab[10] = mk(1, 300, 0, 1, 1, 0);
      exp_tab[11] = mk(1, 255, 0, 0, 1, 0);
      exp_tab[12] = mk(1, 256, 0, 0, 1, 1);
      exp_tab[13] = mk(1, 255, 0, 0, 1, 0);
      exp_tab[14] = mk(1, 256, 0, 0, 1, 1);
      exp_tab[15] = mk(1, 256, 0, 0, 1, 2);
      exp_tab[16] = mk(1, 256, 0, 0, 1, 3);
      exp_tab[17] = mk(1, 256, 1, 0, 2, 4);

      repeat (3) @(negedge clk);
      chk("rst_strobe", 32'(fs_strobe), 0);
      chk("rst_period", 32'(period), 0);
      chk("rst_phase", 32'(phase), 0);
      chk("rst_locked", 32'(locked), 0);
      chk("rst_err", 32'(period_err), 0);
      chk("rst_state", 32'(fsm_state), 0);
      chk("rst_good", 32'(good_cnt), 0);
      rst = 1'b0;

      // lock, stretched period, alternating 255/256, relock
      for (int k = 0; k < 17; k++) begin
         exp_q.push_back(exp_tab[k]);
         drive_cycle(lens[k]);
      end
      // last good edge, then clk_fs stuck low until timeout
      exp_q.push_back(exp_tab[17]);
      exp_q.push_back(mk(0, 256, 0, 1, 0, 0));
      clk_fs = 1'b1;
      repeat (128) @(negedge clk);
      clk_fs = 1'b0;
      wait_empty("timeout_events", 800);
      repeat (4) @(negedge clk);
      chk("stuck_phase", 32'(phase), 32'hFF);
      chk("stuck_locked", 32'(locked), 0);
      chk("stuck_state", 32'(fsm_state), 0);

      // clk_fs already high when reset releases
      rst    = 1'b1;
      clk_fs = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_q.push_back(mk(1, 0, 0, 0, 1, 0));
      @(negedge clk);
      chk("hi_rel_strobe_e1", 32'(fs_strobe), 0);
      @(negedge clk);
      chk("hi_rel_strobe_e2", 32'(fs_strobe), 0);
      @(negedge clk);
      chk("hi_rel_strobe_e3", 32'(fs_strobe), 1);
      @(negedge clk);
      chk("hi_rel_strobe_e4", 32'(fs_strobe), 0);
      chk("hi_rel_period", 32'(period), 0);
      chk("hi_rel_state", 32'(fsm_state), 1);
      repeat (20) @(negedge clk);
      wait_empty("hi_rel_events", 4);

      // lock again, then assert reset between clock edges
      rst    = 1'b1;
      clk_fs = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back(exp_tab[k]);
         drive_cycle(256);
      end
      exp_q.push_back(exp_tab[4]);
      clk_fs = 1'b1;
      repeat (6) @(negedge clk);
      chk("relock_locked", 32'(locked), 1);
      wait_empty("relock_events", 4);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("async_locked", 32'(locked), 0);
      chk("async_period", 32'(period), 0);
      chk("async_phase", 32'(phase), 0);
      chk("async_strobe", 32'(fs_strobe), 0);
      chk("async_err", 32'(period_err), 0);
      chk("async_state", 32'(fsm_state), 0);
      chk("async_good", 32'(good_cnt), 0);
      clk_fs = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("post_rst_locked", 32'(locked), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
